ac_ser_tx: RTL and testbench
============================

// Module: ac_ser_tx
// PURPOSE
//  Parallel-to-serial transmitter that unloads the 16-bit accumulator word.
//  The accumulator register captures a parallel word on acld; this block is the
//  read-out end. It accepts one word per ld_req/ld_ack handshake, then shifts it
//  out one bit per clk on sout, qualified by sframe, with an optional parity bit.
//  It sits between the accumulator output bus and the serial output port.
// PARAMETERS
//  WIDTH      16  data bits per frame (>=2)
//  LSB_FIRST  1   1: bit 0 is sent first; 0: bit WIDTH-1 is sent first
//  PARITY     0   0: none; 1: even parity bit appended; 2: odd parity bit appended
// PORTS
//  clk     in   1      clock; every flop is rising-edge
//  rst_n   in   1      asynchronous active-low reset
//  acclr   in   1      synchronous abort/clear; has priority over ld_req
//  ld_req  in   1      offer of acin; held until it is accepted
//  acin    in   WIDTH  word to send; sampled only on the accept edge
//  ld_ack  out  1      1 = ready to accept; equals (state==IDLE)
//  sout    out  1      serial data; 0 when sframe=0
//  sframe  out  1      1 while sout carries a data or parity bit
//  done    out  1      one-cycle pulse after the last bit of a completed frame
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, shreg=0, bitcnt=0, par=0, sout=0,
//   sframe=0, done=0, ld_ack=1. Reset mid-frame drops the frame immediately.
//  FSM states: IDLE, SHIFT, PAR, DONE.
//   IDLE: ld_ack=1. On an edge with ld_req=1 and acclr=0: shreg<=acin,
//    bitcnt<=0, par<=(PARITY==2), go to SHIFT.
//   SHIFT: sout = shreg[0] (LSB_FIRST=1) or shreg[WIDTH-1] (LSB_FIRST=0);
//    sframe=1. Each edge shifts shreg toward the output end, zero-fills,
//    par<=par^sout, bitcnt<=bitcnt+1. On the edge where bitcnt==WIDTH-1:
//    go to PAR if PARITY!=0, else DONE.
//   PAR: sout=par, sframe=1; exactly one cycle, then DONE.
//   DONE: done=1, sframe=0, sout=0, ld_ack=0; exactly one cycle, then IDLE.
//  Timing: accept at edge N; first bit is valid in cycle N+1; last data bit is
//   in cycle N+WIDTH; parity (if any) is in cycle N+WIDTH+1; done is in the next
//   cycle. The next accept is at the earliest edge after done, so back-to-back
//   frames have a 2-cycle gap with PARITY=0.
//  Outputs sout, sframe, done and ld_ack decode from registered state only,
//   with no combinational path from any input.
//  bitcnt width is $clog2(WIDTH); the count never wraps because it exits at WIDTH-1.
//  acclr=1 in any state: next edge -> IDLE, shreg=0, bitcnt=0, no done pulse.
//   acclr=1 and ld_req=1 together in IDLE: nothing is accepted.
//  ld_req asserted outside IDLE is ignored and is not queued. acin changes after
//   the accept edge do not affect the frame in flight.
// TESTING
//  1 LSB_FIRST=1, PARITY=0: accept acin=16'hA5C3 -> sout over 16 cycles =
//    1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; sframe=1 for exactly those 16 cycles;
//    done in cycle 17; ld_ack=1 in cycle 18.
//  2 LSB_FIRST=0, PARITY=1: acin=16'h8001 -> sout=1,0x14,1 then parity bit 0;
//    sframe=1 for 17 cycles. Repeat with PARITY=2 -> parity bit 1.
//  3 Hold ld_req=1 with acin=16'hFFFF then 16'h0000 -> two frames, first all
//    ones then all zeros; exactly one 2-cycle idle gap between the sframe windows.
//  4 Pulse acclr at data bit 7 -> sframe=0 on the next cycle; no done pulse;
//    ld_ack=1; a new word 16'h1234 is then sent intact.
//  5 Drop rst_n mid-frame (async, between clock edges) -> sout=0, sframe=0,
//    ld_ack=1 immediately; after release, acin=16'h0001 is sent correctly.
//  6 acclr=1 and ld_req=1 together in IDLE -> no frame starts and ld_ack stays 1.

Source files
------------

// File: rtl/ac_ser_tx_if.sv
// Accumulator read-out bus: parallel load handshake on one side, serial frame on the other.
// The master drives the load side and the slave transmits the serial frame.
interface ac_ser_tx_if #(
    parameter int WIDTH = 16
);
    logic             acclr;
    logic             ld_req;
    logic [WIDTH-1:0] acin;
    logic             ld_ack;
    logic             sout;
    logic             sframe;
    logic             done;

    modport master (
        output acclr, ld_req, acin,
        input  ld_ack, sout, sframe, done
    );

    modport slave (
        input  acclr, ld_req, acin,
        output ld_ack, sout, sframe, done
    );
endinterface

// File: rtl/ac_ser_tx.sv
// Parallel-to-serial transmitter for the accumulator word: one word per handshake,
// shifted out one bit per clock with an optional trailing parity bit and a done pulse.
module ac_ser_tx #(
    parameter int WIDTH     = 16,
    parameter int LSB_FIRST = 1,
    parameter int PARITY    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    ac_ser_tx_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0] bitcnt, bitcnt_nxt;
    logic             par, par_nxt;
    logic             out_bit;

    assign out_bit = (LSB_FIRST != 0) ? shreg[0] : shreg[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            par    <= 1'b0;
        end else begin
            state  <= state_nxt;
            shreg  <= shreg_nxt;
            bitcnt <= bitcnt_nxt;
            par    <= par_nxt;
        end
    end

    // acclr overrides everything; the counter is cleared on exit from SHIFT so it never wraps
    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        bitcnt_nxt = bitcnt;
        par_nxt    = par;
        if (bus.acclr) begin
            state_nxt  = IDLE;
            shreg_nxt  = '0;
            bitcnt_nxt = '0;
            par_nxt    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ld_req) begin
                        shreg_nxt  = bus.acin;
                        bitcnt_nxt = '0;
                        par_nxt    = (PARITY == 2);
                        state_nxt  = SHIFT;
                    end
                end
                SHIFT: begin
                    if (LSB_FIRST != 0) begin
                        shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
                    end else begin
                        shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
                    end
                    par_nxt    = par ^ out_bit;
                    bitcnt_nxt = bitcnt + 1'b1;
                    if (bitcnt == LAST_BIT) begin
                        bitcnt_nxt = '0;
                        state_nxt  = (PARITY != 0) ? PAR : DONE;
                    end
                end
                PAR: begin
                    state_nxt = DONE;
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.sout   = 1'b0;
        bus.sframe = 1'b0;
        bus.done   = 1'b0;
        bus.ld_ack = 1'b0;
        case (state)
            IDLE:  bus.ld_ack = 1'b1;
            SHIFT: begin
                bus.sout   = out_bit;
                bus.sframe = 1'b1;
            end
            PAR: begin
                bus.sout   = par;
                bus.sframe = 1'b1;
            end
            DONE:  bus.done = 1'b1;
            default: bus.ld_ack = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_ac_ser_tx.sv
// Bench for ac_ser_tx: three configurations driven in lockstep and checked every cycle
// against a frame-level reference model, plus table-driven captured-frame checks.
module tb_ac_ser_tx;
    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_req = 1'b0;
    logic        acclr = 1'b0;
    logic [15:0] acin = '0;
    logic        check_en = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ac_ser_tx_if #(.WIDTH(W)) bus0 ();
    ac_ser_tx_if #(.WIDTH(W)) bus1 ();
    ac_ser_tx_if #(.WIDTH(W)) bus2 ();

    assign bus0.ld_req = ld_req;
    assign bus1.ld_req = ld_req;
    assign bus2.ld_req = ld_req;
    assign bus0.acclr  = acclr;
    assign bus1.acclr  = acclr;
    assign bus2.acclr  = acclr;
    assign bus0.acin   = acin;
    assign bus1.acin   = acin;
    assign bus2.acin   = acin;

    ac_ser_tx #(.WIDTH(W), .LSB_FIRST(1), .PARITY(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    ac_ser_tx #(.WIDTH(W), .LSB_FIRST(0), .PARITY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    ac_ser_tx #(.WIDTH(W), .LSB_FIRST(0), .PARITY(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    logic [2:0] act_sout, act_frame, act_done, act_ack;
    assign act_sout  = {bus2.sout,   bus1.sout,   bus0.sout};
    assign act_frame = {bus2.sframe, bus1.sframe, bus0.sframe};
    assign act_done  = {bus2.done,   bus1.done,   bus0.done};
    assign act_ack   = {bus2.ld_ack, bus1.ld_ack, bus0.ld_ack};

    function automatic bit cfg_lsb(int k);
        return k == 0;
    endfunction

    function automatic int cfg_par(int k);
        return k;
    endfunction

    function automatic int n_bits(int k);
        return (cfg_par(k) != 0) ? 17 : 16;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of bits followed by one done cycle
    bit mactive [3];
    int mpos    [3];
    bit mseq    [3][17];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n || acclr) begin
                mactive[k] = 1'b0;
            end else if (!mactive[k]) begin
                if (ld_req) begin
                    mactive[k] = 1'b1;
                    mpos[k] = 0;
                    for (int i = 0; i < 16; i++)
                        mseq[k][i] = cfg_lsb(k) ? acin[i] : acin[15-i];
                    if (cfg_par(k) == 1) mseq[k][16] = ($countones(acin) % 2) == 1;
                    if (cfg_par(k) == 2) mseq[k][16] = ($countones(acin) % 2) == 0;
                end
            end else begin
                mpos[k]++;
                if (mpos[k] > n_bits(k)) mactive[k] = 1'b0;
            end
        end
    end

    // {ld_ack, done, sframe, sout}
    function automatic logic [3:0] exp_out(int k);
        if (!mactive[k]) return 4'b1000;
        if (mpos[k] < n_bits(k)) return {3'b001, mseq[k][mpos[k]]};
        return 4'b0100;
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 3; k++) begin
                logic [3:0] e;
                e = exp_out(k);
                check_output($sformatf("d%0d_sout", k),   32'(act_sout[k]),  32'(e[0]));
                check_output($sformatf("d%0d_sframe", k), 32'(act_frame[k]), 32'(e[1]));
                check_output($sformatf("d%0d_done", k),   32'(act_done[k]),  32'(e[2]));
                check_output($sformatf("d%0d_ld_ack", k), 32'(act_ack[k]),   32'(e[3]));
            end
        end
    end

    // Captured serial stream, first-sent bit ends up most significant
    logic [16:0] cap_buf [3];
    int          cap_cnt [3];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (act_frame[k]) begin
                cap_buf[k] = {cap_buf[k][15:0], act_sout[k]};
                cap_cnt[k]++;
            end
        end
    end

    task automatic clear_capture();
        for (int k = 0; k < 3; k++) begin
            cap_buf[k] = '0;
            cap_cnt[k] = 0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (act_ack !== 3'b111 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_output({name, "_idle_timeout"}, 32'(act_ack == 3'b111), 32'd1);
    endtask

    task automatic check_idle_outputs(input string name);
        check_output({name, "_sout"},   32'(act_sout),  32'd0);
        check_output({name, "_sframe"}, 32'(act_frame), 32'd0);
        check_output({name, "_done"},   32'(act_done),  32'd0);
        check_output({name, "_ld_ack"}, 32'(act_ack),   32'h7);
    endtask

    typedef struct {
        logic [15:0] acin;
        logic [15:0] exp0;
        logic [16:0] exp1;
        logic [16:0] exp2;
    } vec_t;

    vec_t vecs [5];

    task automatic apply_stimulus(input int idx);
        wait_idle($sformatf("vec%0d_pre", idx));
        @(negedge clk);
        clear_capture();
        ld_req = 1'b1;
        acin   = vecs[idx].acin;
        @(negedge clk);
        ld_req = 1'b0;
        acin   = 16'($urandom);
        wait_idle($sformatf("vec%0d", idx));
        check_output($sformatf("vec%0d_cnt0", idx),  32'(cap_cnt[0]), 32'd16);
        check_output($sformatf("vec%0d_cnt1", idx),  32'(cap_cnt[1]), 32'd17);
        check_output($sformatf("vec%0d_cnt2", idx),  32'(cap_cnt[2]), 32'd17);
        check_output($sformatf("vec%0d_bits0", idx), 32'(cap_buf[0][15:0]), 32'(vecs[idx].exp0));
        check_output($sformatf("vec%0d_bits1", idx), 32'(cap_buf[1]), 32'(vecs[idx].exp1));
        check_output($sformatf("vec%0d_bits2", idx), 32'(cap_buf[2]), 32'(vecs[idx].exp2));
    endtask

    initial begin
        vecs[0] = '{16'hA5C3, 16'hC3A5, {16'hA5C3, 1'b0}, {16'hA5C3, 1'b1}};
        vecs[1] = '{16'h8001, 16'h8001, {16'h8001, 1'b0}, {16'h8001, 1'b1}};
        vecs[2] = '{16'h1234, 16'h2C48, {16'h1234, 1'b1}, {16'h1234, 1'b0}};
        vecs[3] = '{16'h0001, 16'h8000, {16'h0001, 1'b1}, {16'h0001, 1'b0}};
        vecs[4] = '{16'hFFFF, 16'hFFFF, {16'hFFFF, 1'b0}, {16'hFFFF, 1'b1}};
        clear_capture();

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        check_en = 1'b1;

        for (int i = 0; i < 5; i++) apply_stimulus(i);

        // Held request: two back-to-back frames, all ones then all zeros
        wait_idle("held_pre");
        @(negedge clk);
        clear_capture();
        ld_req = 1'b1;
        acin   = 16'hFFFF;
        @(negedge clk);
        acin   = 16'h0000;
        repeat (19) @(negedge clk);
        ld_req = 1'b0;
        wait_idle("held");
        check_output("held_cnt0", 32'(cap_cnt[0]), 32'd32);
        check_output("held_cnt1", 32'(cap_cnt[1]), 32'd34);

        // Abort during data bit 7
        @(negedge clk);
        ld_req = 1'b1;
        acin   = 16'hA5C3;
        @(negedge clk);
        ld_req = 1'b0;
        repeat (7) @(negedge clk);
        acclr = 1'b1;
        @(negedge clk);
        acclr = 1'b0;
        check_idle_outputs("abort");
        apply_stimulus(2);

        // Asynchronous reset between edges in the middle of a frame
        @(negedge clk);
        ld_req = 1'b1;
        acin   = 16'hA5C3;
        @(negedge clk);
        ld_req = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(3);

        // Clear together with request in IDLE must not start a frame
        @(negedge clk);
        ld_req = 1'b1;
        acclr  = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("clr_req");
        ld_req = 1'b0;
        acclr  = 1'b0;

        repeat (400) begin
            @(negedge clk);
            ld_req = 1'($urandom_range(0, 1));
            acclr  = ($urandom_range(0, 19) == 0);
            acin   = 16'($urandom);
        end
        @(negedge clk);
        ld_req = 1'b0;
        acclr  = 1'b0;
        wait_idle("random");

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
